// File: rtl/pc_pkg.sv
// pc_pkg: datapath-wide address constants shared by the fetch-path blocks
package pc_pkg;
    localparam int ADDR_WIDTH = 32;
    localparam logic [ADDR_WIDTH-1:0] TEXT_BASE = 32'h00400000;
endpackage

// File: rtl/pc.sv
// pc: program counter register loaded from the next-PC logic every rising edge
module pc
    import pc_pkg::*;
#(
    parameter int WIDTH = ADDR_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = TEXT_BASE
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] NextPC,
    output logic [WIDTH-1:0] PC
);
    logic [WIDTH-1:0] r_pc;
    always_ff @(posedge Clk) r_pc <= Reset ? RESET_VALUE : NextPC;
    assign PC = r_pc;
endmodule

// File: tb/tb_pc.sv
// tb_pc: vector table plus hand-written sequences checking the program counter register
module tb_pc;
    import pc_pkg::*;
    logic        Clk;
    logic        Reset, Reset16;
    logic [31:0] NextPC, PC;
    logic [15:0] NextPC16, PC16;
    int checks, failures;

    typedef struct {
        logic        rst;
        logic [31:0] nxt;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;

    vec_t vecs[12];
    sb_t  sb[$];

    pc #(ADDR_WIDTH, TEXT_BASE) dut (.Clk(Clk), .Reset(Reset), .NextPC(NextPC), .PC(PC));
    pc #(16, 16'h0100) dut16 (.Clk(Clk), .Reset(Reset16), .NextPC(NextPC16), .PC(PC16));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic edge_and_compare();
        sb_t e;
        @(posedge Clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard: got empty queue expected an entry");
        end else begin
            e = sb.pop_front();
            check(e.name, PC, e.exp);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        Reset = 1'b1;
        NextPC = '0;
        Reset16 = 1'b1;
        NextPC16 = '0;
        vecs[0]  = '{1'b1, 32'h12345678, 32'h00400000};
        vecs[1]  = '{1'b0, 32'h00400004, 32'h00400004};
        vecs[2]  = '{1'b0, 32'h00400008, 32'h00400008};
        vecs[3]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[4]  = '{1'b0, 32'h00000000, 32'h00000000};
        vecs[5]  = '{1'b0, 32'h00400003, 32'h00400003};
        vecs[6]  = '{1'b0, 32'h0040001C, 32'h0040001C};
        vecs[7]  = '{1'b1, 32'h00400020, 32'h00400000};
        vecs[8]  = '{1'b0, 32'h00400004, 32'h00400004};
        vecs[9]  = '{1'b1, 32'hFFFFFFFF, 32'h00400000};
        vecs[10] = '{1'b0, 32'hAAAAAAAA, 32'hAAAAAAAA};
        vecs[11] = '{1'b0, 32'h55555555, 32'h55555555};
        @(negedge Clk);
        for (int i = 0; i < 12; i++) begin
            Reset = vecs[i].rst;
            NextPC = vecs[i].nxt;
            sb.push_back('{$sformatf("vec%0d", i), vecs[i].exp});
            edge_and_compare();
        end
        // Inputs changing between rising edges must not disturb PC
        NextPC = 32'hDEADBEEF;
        Reset = 1'b1;
        #2;
        check("mid_hold", PC, 32'h55555555);
        @(negedge Clk);
        #1;
        check("negedge_hold", PC, 32'h55555555);
        Reset = 1'b0;
        sb.push_back('{"load_after_glitch", 32'hDEADBEEF});
        edge_and_compare();
        NextPC = 32'h00400040;
        #3;
        Reset = 1'b1;
        @(negedge Clk);
        #1;
        Reset = 1'b0;
        check("fall_reset_hold", PC, 32'hDEADBEEF);
        sb.push_back('{"load_after_fall_reset", 32'h00400040});
        edge_and_compare();
        Reset16 = 1'b1;
        NextPC16 = 16'hFFFF;
        @(posedge Clk);
        #1;
        check("w16_reset", {16'h0, PC16}, 32'h00000100);
        Reset16 = 1'b0;
        NextPC16 = 16'hABCD;
        @(posedge Clk);
        #1;
        check("w16_load", {16'h0, PC16}, 32'h0000ABCD);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
